// File: rtl/word_red_seq.sv
// word_red_seq
//   Sequencer for the word-level Montgomery reduction unit. Each pass of the
//   unit strips R = 26 bits from its operand and has a fixed pipeline latency
//   of RED_LAT cycles. One job (a K-bit product plus its modulus) is accepted
//   at a time. The job runs ITER passes; each pass result red_T is fed back,
//   zero-extended, as the next red_C. The final value goes out on a
//   valid/ready port.
//
//   Optional feature macro: WORD_RED_FINAL_SUB_EN
//     defined   : a one-cycle SUB state conditionally subtracts q, so out_T
//                 is in [0, q).
//     undefined : RUN goes straight to DONE, so out_T is the raw last-pass
//                 value in [0, 2q).
//
//   Handshake rule (both ports): a transfer happens on the rising clk edge
//   where valid & ready are both high. The producer holds valid and data
//   until that edge, and the consumer may hold ready low for any length of
//   time.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_ready/in_C/in_q   job input (product, odd modulus)
//   red_C         operand to the reduction unit (registered)
//   red_qH        q[Q_LEN-1:R+Y] of the current job (registered)
//   red_T         reduction unit result
//   out_valid/out_ready/out_T     reduced result output (out_T registered)
//   busy          high in every state except IDLE
module word_red_seq #(
   parameter int K       = 90,
   parameter int Q_LEN   = 64,
   parameter int Y       = 12,
   parameter int RED_LAT = 3,
   parameter int ITER    = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [K-1:0]            in_C,
   input  logic [Q_LEN-1:0]        in_q,
   output logic [K-1:0]            red_C,
   output logic [Q_LEN-26-Y-1:0]   red_qH,
   input  logic [K-26-1:0]         red_T,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [K-26-1:0]         out_T,
   output logic                    busy
);

   localparam int R  = 26;
   localparam int TW = K - R;
   localparam int LW = (RED_LAT > 1) ? $clog2(RED_LAT) : 1;
   localparam int PW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [LW-1:0] LAT_LAST  = LW'(RED_LAT - 1);
   localparam logic [PW-1:0] PASS_LAST = PW'(ITER - 1);

   // Each pass result is below 2q. The feedback path is TW bits wide, so it
   // must at least hold the modulus. When TW == Q_LEN, q must leave its top
   // bit clear so that 2q still fits.
   generate
      if (TW < Q_LEN) begin : g_width_err
         $error("word_red_seq: K-R too narrow for Q_LEN");
      end
      if (RED_LAT < 1) begin : g_lat_err
         $error("word_red_seq: RED_LAT must be >= 1");
      end
      if (ITER < 1) begin : g_iter_err
         $error("word_red_seq: ITER must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_SUB  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [LW-1:0]   lat_cnt;
   logic [PW-1:0]   pass_cnt;
   logic [Q_LEN-1:0] q_reg;
   logic            accept;
   logic            pass_end;
   logic            last_pass;

   assign accept    = in_valid & in_ready;
   // The edge on which red_T holds the result of the current pass.
   assign pass_end  = (state == S_RUN) && (lat_cnt == LAT_LAST);
   assign last_pass = (pass_cnt == PASS_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (pass_end && last_pass) begin
`ifdef WORD_RED_FINAL_SUB_EN
               state_nx = S_SUB;
`else
               state_nx = S_DONE;
`endif
            end
         end
         S_SUB: begin
            state_nx = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Datapath. red_C is written only on accept and on intermediate pass
   // edges, so the unit always sees a stable operand for a whole pass.
   always_ff @(posedge clk) begin
      if (rst) begin
         red_C    <= '0;
         red_qH   <= '0;
         q_reg    <= '0;
         out_T    <= '0;
         pass_cnt <= '0;
         lat_cnt  <= '0;
      end else begin
         if (accept) begin
            red_C    <= in_C;
            red_qH   <= in_q[Q_LEN-1:R+Y];
            q_reg    <= in_q;
            pass_cnt <= '0;
            lat_cnt  <= '0;
         end else if (state == S_RUN) begin
            if (pass_end) begin
               lat_cnt <= '0;
               if (!last_pass) begin
                  red_C    <= {{R{1'b0}}, red_T};
                  pass_cnt <= pass_cnt + 1'b1;
               end else begin
                  out_T <= red_T;
               end
            end else begin
               lat_cnt <= lat_cnt + 1'b1;
            end
         end
`ifdef WORD_RED_FINAL_SUB_EN
         else if (state == S_SUB) begin
            // out_T < 2q on entry, so one conditional subtract is enough.
            if (out_T >= TW'(q_reg)) begin
               out_T <= out_T - TW'(q_reg);
            end
         end
`endif
      end
   end

`ifndef WORD_RED_FINAL_SUB_EN
   // The modulus register only feeds the final subtract.
   logic unused_q;
   assign unused_q = ^q_reg;
`endif

endmodule

// File: tb/tb_word_red_seq.sv
// tb_word_red_seq
//   Self-checking bench for word_red_seq. A behavioural model of the reduction
//   unit drives red_T: T = (C + m*q) >> 26 with m = (-C * q^-1) mod 2^26,
//   delayed RED_LAT cycles from the red_C load. The final results are checked
//   against the algebraic identity out_T * 2^78 == C (mod q) and against a
//   range bound. Per-pass red_C values come from chaining the unit model.
module tb_word_red_seq;
   localparam int K       = 90;
   localparam int Q_LEN   = 64;
   localparam int Y       = 12;
   localparam int RED_LAT = 3;
   localparam int ITER    = 3;
   localparam int R       = 26;
   localparam int TW      = K - R;
`ifdef WORD_RED_FINAL_SUB_EN
   localparam int LAT     = ITER * RED_LAT + 1;
   localparam bit SUB     = 1'b1;
`else
   localparam int LAT     = ITER * RED_LAT;
   localparam bit SUB     = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [K-1:0]     in_C;
   logic [Q_LEN-1:0] in_q;
   logic [K-1:0]     red_C;
   logic [Q_LEN-R-Y-1:0] red_qH;
   logic [TW-1:0]    red_T;
   logic             out_valid;
   logic             out_ready;
   logic [TW-1:0]    out_T;
   logic             busy;

   int n_total = 0;
   int n_bad   = 0;

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   word_red_seq #(
      .K(K), .Q_LEN(Q_LEN), .Y(Y), .RED_LAT(RED_LAT), .ITER(ITER)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_C      (in_C),
      .in_q      (in_q),
      .red_C     (red_C),
      .red_qH    (red_qH),
      .red_T     (red_T),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_T     (out_T),
      .busy      (busy)
   );

   // Behavioural reduction unit.
   function automatic logic [TW-1:0] red_pass(input logic [K-1:0] c, input logic [63:0] q);
      logic [63:0]  x;
      logic [25:0]  nc;
      logic [63:0]  p;
      logic [25:0]  m;
      logic [127:0] s;
      x = q;  // correct inverse mod 8; each Newton step doubles the bits
      for (int i = 0; i < 5; i++) begin
         x = x * (64'd2 - q * x);
      end
      nc = -c[25:0];
      p  = {38'b0, nc} * x;
      m  = p[25:0];
      s  = {38'b0, c} + ({102'b0, m} * {64'b0, q});
      return s[K-1:R];
   endfunction

   logic [K-1:0]  c_d1 = '0;
   logic [K-1:0]  c_d2 = '0;
   logic [63:0]   unit_q = 64'd1;

   // red_T before edge n reflects red_C as loaded at edge n-RED_LAT.
   always @(posedge clk) begin
      c_d1 <= red_C;
      c_d2 <= c_d1;
   end
   assign red_T = red_pass(c_d2, unit_q);

   // scoreboard checking task
   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rand_q();
      logic [63:0] q;
      q = {$urandom, $urandom};
      q[63] = 1'b0;
      q[0]  = 1'b1;
      return q;
   endfunction

   function automatic logic [K-1:0] rand_c(input logic [63:0] q);
      logic [K-1:0] c;
      logic [K-1:0] lim;
      c   = {$urandom, $urandom, $urandom};
      lim = {26'b0, q} << 26;
      return c % lim;
   endfunction

   // driver task: called at a negedge with the DUT idle.
   task automatic run_job(input logic [K-1:0] c, input logic [63:0] q, input int hold);
      logic [TW-1:0]  pv [ITER];
      logic [K-1:0]   cc;
      logic [K-1:0]   exp_c;
      logic [TW-1:0]  exp_t;
      logic [TW-1:0]  held_t;
      logic [K-1:0]   held_c;
      logic [191:0]   lhs;
      logic [64:0]    bound;
      int             waited;
      int             pidx;
      unit_q   = q;
      in_valid = 1'b1;
      in_C     = c;
      in_q     = q;
      waited   = 0;
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check_val("accept_wait", waited, 0);
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_C     = {$urandom, $urandom, $urandom};
      in_q     = {$urandom, $urandom};

      cc = c;
      for (int p = 0; p < ITER; p++) begin
         pv[p] = red_pass(cc, q);
         cc    = {26'b0, pv[p]};
      end

      for (int k = 0; k <= LAT; k++) begin
         pidx  = k / RED_LAT;
         if (pidx > ITER - 1) pidx = ITER - 1;
         exp_c = (pidx == 0) ? c : {26'b0, pv[pidx-1]};
         check_val("red_c", red_C, exp_c);
         check_val("out_valid_lat", out_valid, (k == LAT));
         check_val("in_ready_busy", in_ready, 1'b0);
         if (k == 0) check_val("red_qh", red_qH, q[63:38]);
         if (k < LAT) @(negedge clk);
      end

      exp_t = pv[ITER-1];
      if (SUB && exp_t >= q) exp_t = exp_t - q;
      check_val("out_t", out_T, exp_t);
      lhs = {128'b0, out_T} << 78;
      check_val("mod_eq", lhs % {128'b0, q}, c % {26'b0, q});
      bound = SUB ? {1'b0, q} : ({1'b0, q} << 1);
      check_val("range", {1'b0, out_T} < bound, 1'b1);

      held_t = out_T;
      held_c = red_C;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_C     = {$urandom, $urandom, $urandom};
         @(negedge clk);
         check_val("hold_out_t", out_T, held_t);
         check_val("hold_valid", out_valid, 1'b1);
         check_val("hold_in_ready", in_ready, 1'b0);
         check_val("hold_no_accept", red_C, held_c);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("release_valid", out_valid, 1'b0);
      check_val("release_in_ready", in_ready, 1'b1);
      check_val("release_busy", busy, 1'b0);
   endtask

   logic [63:0] q61;
   logic [63:0] qr;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_C      = '0;
      in_q      = '0;
      repeat (2) @(negedge clk);
      check_val("rst_in_ready", in_ready, 1'b1);
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_red_c", red_C, '0);
      check_val("rst_red_qh", red_qH, '0);
      check_val("rst_out_t", out_T, '0);
      rst = 1'b0;
      @(negedge clk);

      // zero product
      run_job('0, rand_q(), 0);

      // C == q
      q61 = (64'd1 << 61) - 64'd1;
      run_job({26'b0, q61}, q61, 1);
      if (SUB) check_val("cq_sub", out_T, '0);
      else     check_val("cq_raw", (out_T == '0) || (out_T == q61), 1'b1);

      // backpressure with a second offer during hold
      qr = rand_q();
      run_job(rand_c(qr), qr, 20);
      qr = rand_q();
      run_job(rand_c(qr), qr, 0);

      // reset in mid-job
      qr = rand_q();
      unit_q   = qr;
      in_valid = 1'b1;
      in_C     = rand_c(qr);
      in_q     = qr;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst_busy", busy, 1'b0);
      check_val("midrst_in_ready", in_ready, 1'b1);
      check_val("midrst_red_c", red_C, '0);
      check_val("midrst_out_t", out_T, '0);
      check_val("midrst_out_valid", out_valid, 1'b0);
      run_job('0, qr, 0);
      check_val("post_rst_zero", out_T, '0);

      // reset and in_valid together
      rst      = 1'b1;
      in_valid = 1'b1;
      in_C     = {$urandom, $urandom, $urandom};
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      check_val("rst_wins_busy", busy, 1'b0);
      check_val("rst_wins_red_c", red_C, '0);

      // random jobs
      for (int j = 0; j < 1000; j++) begin
         qr = rand_q();
         run_job(rand_c(qr), qr, $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
